// File: rtl/leading_one_scanner_if.sv
// Handshake bundle for the leading-one scanner: vector input side and
// index-beat output side. The scanner itself connects through the slave
// modport; a producer/consumer pair would use the master modport.
interface leading_one_scanner_if #(
   parameter int WIDTH = 9,
   parameter int IDX_W = $clog2(WIDTH)
);

   logic             in_valid_i;
   logic             in_ready_o;
   logic [WIDTH-1:0] number_i;
   logic             dir_i;

   logic             out_valid_o;
   logic             out_ready_i;
   logic [IDX_W-1:0] index_o;
   logic [IDX_W-1:0] seq_o;
   logic             last_o;
   logic             zero_o;

   modport master (
      output in_valid_i,
      output number_i,
      output dir_i,
      output out_ready_i,
      input  in_ready_o,
      input  out_valid_o,
      input  index_o,
      input  seq_o,
      input  last_o,
      input  zero_o
   );

   modport slave (
      input  in_valid_i,
      input  number_i,
      input  dir_i,
      input  out_ready_i,
      output in_ready_o,
      output out_valid_o,
      output index_o,
      output seq_o,
      output last_o,
      output zero_o
   );

endinterface

// File: rtl/leading_one_scanner.sv
// Sequential set-bit walker. Accepts a WIDTH-bit vector and emits the index
// of every set bit, one beat per bit, either MSB-first or LSB-first. An
// all-zero vector produces a single beat flagged with zero_o. All outputs
// come from registers so there is no input-to-output combinational path.
module leading_one_scanner #(
   parameter int WIDTH = 9,
   parameter int IDX_W = $clog2(WIDTH)
) (
   input logic                  clk_i,
   input logic                  rst_ni,
   leading_one_scanner_if.slave bus
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_SCAN = 1'b1;

   localparam logic [WIDTH-1:0] WORK_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [IDX_W-1:0] SEQ_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};

   logic [0:0]       state_q, state_d;
   logic [WIDTH-1:0] work_q, work_d;
   logic             dir_q, dir_d;
   logic             zero_q, zero_d;
   logic [IDX_W-1:0] seq_q, seq_d;

   logic [IDX_W-1:0] msb_idx;
   logic [IDX_W-1:0] lsb_idx;
   logic [IDX_W-1:0] cur_idx;
   logic             one_hot;
   logic             in_scan;
   logic             cur_last;
   logic             accept;
   logic             beat_done;

   // Highest set bit of the work vector; later iterations overwrite earlier ones
   always_comb begin
      msb_idx = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (work_q[i]) begin
            msb_idx = IDX_W'(i);
         end
      end
   end

   // Lowest set bit of the work vector, scanning downward so bit 0 wins last
   always_comb begin
      lsb_idx = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (work_q[i]) begin
            lsb_idx = IDX_W'(i);
         end
      end
   end

   // Per-beat decode: current index in the latched direction and last-beat detection
   always_comb begin
      in_scan   = (state_q == ST_SCAN);
      cur_idx   = dir_q ? lsb_idx : msb_idx;
      one_hot   = (work_q != '0) && ((work_q & (work_q - WORK_ONE)) == '0);
      cur_last  = zero_q || one_hot;
      accept    = (state_q == ST_IDLE) && bus.in_valid_i;
      beat_done = in_scan && bus.out_ready_i;
   end

   // Next-state logic for the IDLE/SCAN walk
   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      dir_d   = dir_q;
      zero_d  = zero_q;
      seq_d   = seq_q;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               work_d  = bus.number_i;
               dir_d   = bus.dir_i;
               zero_d  = (bus.number_i == '0);
               seq_d   = '0;
               state_d = ST_SCAN;
            end
         end

         ST_SCAN: begin
            if (beat_done) begin
               if (cur_last) begin
                  state_d = ST_IDLE;
               end else begin
                  for (int i = 0; i < WIDTH; i++) begin
                     if (IDX_W'(i) == cur_idx) begin
                        work_d[i] = 1'b0;
                     end
                  end
                  seq_d = seq_q + SEQ_ONE;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers; an async reset drops any in-flight vector
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         work_q  <= '0;
         dir_q   <= 1'b0;
         zero_q  <= 1'b0;
         seq_q   <= '0;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         dir_q   <= dir_d;
         zero_q  <= zero_d;
         seq_q   <= seq_d;
      end
   end

   // Outputs are forced to zero outside SCAN so IDLE never shows stale beat data
   always_comb begin
      bus.in_ready_o  = (state_q == ST_IDLE);
      bus.out_valid_o = in_scan;
      bus.index_o     = (in_scan && !zero_q) ? cur_idx : '0;
      bus.seq_o       = in_scan ? seq_q : '0;
      bus.last_o      = in_scan && cur_last;
      bus.zero_o      = in_scan && zero_q;
   end

endmodule

// File: tb/tb_leading_one_scanner.sv
// Testbench for leading_one_scanner: a table of directed vectors, a mid-scan
// reset sequence and a sweep of all vectors in both directions. Expected
// beats come from a bench-side model pushed into a scoreboard queue.
module tb_leading_one_scanner;

   localparam int WIDTH = 9;
   localparam int IDX_W = 4;

   typedef struct {
      logic [IDX_W-1:0] index;
      logic [IDX_W-1:0] seq;
      logic             last;
      logic             zero;
   } beat_t;

   typedef struct {
      string            name;
      logic [WIDTH-1:0] number;
      logic             dir;
      bit               toggle_dir;
      bit               pulse_valid;
      int               stall_seq;
      int               stall_cycles;
      int               exp_beats;
      logic [IDX_W-1:0] exp_first;
   } vec_t;

   logic clk;
   logic rst_n;

   int checks_total;
   int checks_passed;

   beat_t exp_q[$];

   leading_one_scanner_if #(.WIDTH(WIDTH), .IDX_W(IDX_W)) bus ();

   leading_one_scanner #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   // Free-running clock, period 10
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case anything ever stalls
   initial begin
      #5000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks_total++;
      if (act === exp) begin
         checks_passed++;
      end else begin
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: list the set bits in the requested order
   task automatic push_model(input logic [WIDTH-1:0] num, input logic d);
      logic [IDX_W-1:0] order[$];
      beat_t b;
      for (int k = 0; k < WIDTH; k++) begin
         int pos;
         pos = d ? k : (WIDTH - 1 - k);
         if (num[pos]) order.push_back(IDX_W'(pos));
      end
      if (order.size() == 0) begin
         b.index = '0;
         b.seq   = '0;
         b.last  = 1'b1;
         b.zero  = 1'b1;
         exp_q.push_back(b);
      end else begin
         for (int k = 0; k < order.size(); k++) begin
            b.index = order[k];
            b.seq   = IDX_W'(k);
            b.last  = (k == order.size() - 1);
            b.zero  = 1'b0;
            exp_q.push_back(b);
         end
      end
   endtask

   // Send one vector and consume all its beats, comparing each against the scoreboard
   task automatic apply_stimulus(input logic [WIDTH-1:0] num, input logic d,
                                 input bit toggle_dir, input bit pulse_valid,
                                 input int stall_seq, input int stall_cycles,
                                 output int beats, output logic [IDX_W-1:0] first_idx);
      int guard;
      int cycles;
      int stalled;
      beat_t e;
      beats     = 0;
      first_idx = '0;
      guard     = 0;
      while (!bus.in_ready_o && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (!bus.in_ready_o) begin
         check_output("ready_wait_timeout", 32'(bus.in_ready_o), 32'd1);
         return;
      end
      bus.in_valid_i  = 1'b1;
      bus.number_i    = num;
      bus.dir_i       = d;
      bus.out_ready_i = 1'b1;
      push_model(num, d);
      @(negedge clk);
      bus.in_valid_i = 1'b0;
      bus.number_i   = WIDTH'($urandom);
      cycles  = 0;
      stalled = 0;
      while (exp_q.size() > 0 && cycles < 200) begin
         e = exp_q[0];
         check_output("out_valid", 32'(bus.out_valid_o), 32'd1);
         check_output("index", 32'(bus.index_o), 32'(e.index));
         check_output("seq", 32'(bus.seq_o), 32'(e.seq));
         check_output("last", 32'(bus.last_o), 32'(e.last));
         check_output("zero", 32'(bus.zero_o), 32'(e.zero));
         if (int'(bus.seq_o) == stall_seq && stalled < stall_cycles) begin
            bus.out_ready_i = 1'b0;
            stalled++;
         end else begin
            bus.out_ready_i = 1'b1;
         end
         if (toggle_dir) bus.dir_i = ~bus.dir_i;
         if (pulse_valid) begin
            bus.in_valid_i = (cycles % 2 == 1);
            bus.number_i   = WIDTH'($urandom);
         end
         if (bus.out_valid_o && bus.out_ready_i) begin
            if (beats == 0) first_idx = bus.index_o;
            beats++;
            void'(exp_q.pop_front());
         end
         @(negedge clk);
         cycles++;
      end
      bus.in_valid_i  = 1'b0;
      bus.out_ready_i = 1'b1;
      if (exp_q.size() > 0) begin
         check_output("beat_timeout", 32'(exp_q.size()), 32'd0);
         exp_q.delete();
      end
      check_output("in_ready_after", 32'(bus.in_ready_o), 32'd1);
      check_output("idle_valid_after", 32'(bus.out_valid_o), 32'd0);
   endtask

   vec_t vecs[$];

   initial begin
      int beats;
      logic [IDX_W-1:0] first;
      vec_t v;

      checks_total  = 0;
      checks_passed = 0;

      v = '{"msb_first",    9'b100000101, 1'b0, 1'b0, 1'b0, -1, 0, 3, 4'd8}; vecs.push_back(v);
      v = '{"lsb_toggle",   9'b100000101, 1'b1, 1'b1, 1'b0, -1, 0, 3, 4'd0}; vecs.push_back(v);
      v = '{"zero_vec",     9'h000,       1'b0, 1'b0, 1'b0, -1, 0, 1, 4'd0}; vecs.push_back(v);
      v = '{"ones_stall",   9'h1FF,       1'b0, 1'b0, 1'b1,  1, 3, 9, 4'd8}; vecs.push_back(v);
      v = '{"top_bit_msb",  9'h100,       1'b0, 1'b0, 1'b0, -1, 0, 1, 4'd8}; vecs.push_back(v);
      v = '{"top_bit_lsb",  9'h100,       1'b1, 1'b0, 1'b0, -1, 0, 1, 4'd8}; vecs.push_back(v);
      v = '{"bit0_msb",     9'h001,       1'b0, 1'b0, 1'b0, -1, 0, 1, 4'd0}; vecs.push_back(v);
      v = '{"nibble_lsb",   9'h0F0,       1'b1, 1'b0, 1'b0, -1, 0, 4, 4'd4}; vecs.push_back(v);
      v = '{"ones_lsb",     9'h1FF,       1'b1, 1'b0, 1'b0, -1, 0, 9, 4'd0}; vecs.push_back(v);

      bus.in_valid_i  = 1'b0;
      bus.number_i    = '0;
      bus.dir_i       = 1'b0;
      bus.out_ready_i = 1'b1;
      rst_n           = 1'b0;

      repeat (3) @(negedge clk);
      check_output("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
      check_output("rst_in_ready", 32'(bus.in_ready_o), 32'd1);
      check_output("rst_index", 32'(bus.index_o), 32'd0);
      check_output("rst_seq", 32'(bus.seq_o), 32'd0);
      check_output("rst_last", 32'(bus.last_o), 32'd0);
      check_output("rst_zero", 32'(bus.zero_o), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < vecs.size(); i++) begin
         apply_stimulus(vecs[i].number, vecs[i].dir, vecs[i].toggle_dir, vecs[i].pulse_valid,
                        vecs[i].stall_seq, vecs[i].stall_cycles, beats, first);
         check_output({vecs[i].name, "_beats"}, 32'(beats), 32'(vecs[i].exp_beats));
         check_output({vecs[i].name, "_first"}, 32'(first), 32'(vecs[i].exp_first));
      end

      // Reset in the middle of the second beat of 9'h0F0
      bus.in_valid_i = 1'b1;
      bus.number_i   = 9'h0F0;
      bus.dir_i      = 1'b0;
      @(negedge clk);
      bus.in_valid_i = 1'b0;
      check_output("midrst_beat0_index", 32'(bus.index_o), 32'd7);
      @(negedge clk);
      check_output("midrst_beat1_valid", 32'(bus.out_valid_o), 32'd1);
      check_output("midrst_beat1_index", 32'(bus.index_o), 32'd6);
      check_output("midrst_beat1_seq", 32'(bus.seq_o), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_output("midrst_valid_drop", 32'(bus.out_valid_o), 32'd0);
      check_output("midrst_ready", 32'(bus.in_ready_o), 32'd1);
      check_output("midrst_seq", 32'(bus.seq_o), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check_output("postrst_no_beat", 32'(bus.out_valid_o), 32'd0);
         check_output("postrst_ready", 32'(bus.in_ready_o), 32'd1);
      end

      // Every vector, both directions, against the model
      for (int d = 0; d < 2; d++) begin
         for (int n = 0; n < (1 << WIDTH); n++) begin
            logic [WIDTH-1:0] num;
            int exp_beats;
            num = WIDTH'(n);
            exp_beats = (num == '0) ? 1 : $countones(num);
            apply_stimulus(num, d[0], 1'b0, 1'b0, -1, 0, beats, first);
            check_output("sweep_beats", 32'(beats), 32'(exp_beats));
         end
      end

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
